// File: rtl/sdm_pkg.sv
// Shared widths, full-scale constants and the integrator clamp for the
// second-order sigma-delta transmitter.
package sdm_pkg;
  localparam int SDM_OVERSAMPLE = 256;
  localparam int SDM_DATA_WIDTH = 16;
  localparam int SDM_ACC_WIDTH  = SDM_DATA_WIDTH + 4;
  localparam int SDM_SUM_WIDTH  = SDM_ACC_WIDTH + 2;

  typedef logic signed [SDM_DATA_WIDTH-1:0] sdm_data_t;
  typedef logic signed [SDM_ACC_WIDTH-1:0]  sdm_acc_t;
  typedef logic signed [SDM_SUM_WIDTH-1:0]  sdm_sum_t;

  localparam sdm_sum_t SDM_FS      = sdm_sum_t'(2**(SDM_DATA_WIDTH-1));
  localparam sdm_sum_t SDM_ACC_MAX = sdm_sum_t'(2**(SDM_ACC_WIDTH-1) - 1);
  localparam sdm_sum_t SDM_ACC_MIN = sdm_sum_t'(-(2**(SDM_ACC_WIDTH-1)));

  function automatic sdm_acc_t sat_acc(input sdm_sum_t s);
    if (s > SDM_ACC_MAX)
      return sdm_acc_t'(SDM_ACC_MAX);
    else if (s < SDM_ACC_MIN)
      return sdm_acc_t'(SDM_ACC_MIN);
    else
      return sdm_acc_t'(s);
  endfunction
endpackage

// File: rtl/sdm2_core.sv
// Boser-Wooley CIFB second-order loop: two clamped integrators and a
// sign quantiser, all updated from the previous cycle's registers.
module sdm2_core
  import sdm_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  sdm_data_t x,
  output logic      out
);
  sdm_acc_t i1, i2;
  sdm_acc_t i1_n, i2_n;
  sdm_sum_t v, sum1, sum2;

  always_comb begin
    v    = out ? SDM_FS : -SDM_FS;
    sum1 = sdm_sum_t'(i1) + sdm_sum_t'(x) - v;
    sum2 = sdm_sum_t'(i2) + sdm_sum_t'(i1) - (v <<< 1);
  end

  assign i1_n = sat_acc(sum1);
  assign i2_n = sat_acc(sum2);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i1  <= '0;
      i2  <= '0;
      out <= 1'b0;
    end else begin
      i1  <= i1_n;
      i2  <= i2_n;
      out <= ~i2_n[SDM_ACC_WIDTH-1];
    end
  end
endmodule

// File: rtl/sdm2_tx.sv
// Sigma-delta transmitter top: frame counter, single-entry sample buffer
// with valid/ready intake, zero-order hold register and sticky underrun.
module sdm2_tx
  import sdm_pkg::*;
#(
  parameter int OVERSAMPLE  = SDM_OVERSAMPLE,
  parameter int DATA_WIDTH  = SDM_DATA_WIDTH,
  parameter int CLOCK_WIDTH = $clog2(OVERSAMPLE)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out,
  output logic                         frame_strobe,
  output logic                         underrun
);
  localparam logic [CLOCK_WIDTH-1:0] CNT_LAST = CLOCK_WIDTH'(OVERSAMPLE - 1);

  logic [CLOCK_WIDTH-1:0]       cnt;
  logic signed [DATA_WIDTH-1:0] x;
  logic signed [DATA_WIDTH-1:0] buf_data;
  logic                         buf_full;
  logic                         frame_end;
  logic                         accept;

  assign frame_end = (cnt == CNT_LAST);
  assign in_ready  = !buf_full || frame_end;
  assign accept    = in_valid && in_ready;

  // A sample accepted on frame_end lands in buf_data; it never skips to x.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt          <= '0;
      x            <= '0;
      buf_data     <= '0;
      buf_full     <= 1'b0;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      cnt          <= cnt + CLOCK_WIDTH'(1);
      frame_strobe <= frame_end;
      if (frame_end) begin
        if (buf_full) begin
          x        <= buf_data;
          buf_full <= 1'b0;
        end else begin
          underrun <= 1'b1;
        end
      end
      if (accept) begin
        buf_data <= in_data;
        buf_full <= 1'b1;
      end
    end
  end

  sdm2_core u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .out     (out)
  );
endmodule
